iot_pool_monitor: RTL and testbench
===================================

IOT_POOL_MONITOR -- requirements
Module: iot_pool_monitor

Interface
REQ-001 SHALL have parameter NCH, default 4: number of independent device channels (1..16).
REQ-002 SHALL have parameter WIDTH, default 8: per-channel counter width in bits (2..16).
REQ-003 SHALL have parameter INIT, default 0: counter value after reset or clear; must be < 2^WIDTH.
REQ-004 SHALL have parameter SAT, default 0: 0 = wrap-around arithmetic, 1 = saturating arithmetic.
REQ-005 SHALL have parameter ALARM_TH, default 2^WIDTH-1: per-channel alarm threshold.
REQ-006 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port clr  input  1  synchronous clear of all channels, active-high.
REQ-009 SHALL have port change  input  NCH  per-channel event strobe; bit i qualifies on_off[i].
REQ-010 SHALL have port on_off  input  NCH  per-channel direction: 1 = device on (up), 0 = device off (down).
REQ-011 SHALL have port count_flat  output  NCH*WIDTH  channel i counter at bits [i*WIDTH +: WIDTH].
REQ-012 SHALL have port total  output  WIDTH+clog2(NCH)+1  registered sum of all channel counters.
REQ-013 SHALL have port alarm  output  NCH  bit i high while count[i] >= ALARM_TH.
REQ-014 SHALL have port ovf_evt  output  NCH  one-cycle pulse on channel i wrap or saturation hit.
REQ-015 SHALL have port peak_flat  output  NCH*WIDTH  per-channel high-water mark (see Configuration).

Function
REQ-016 Per channel, each edge: clr -> INIT; else change=1,on_off=1 -> +1; change=1,on_off=0 -> -1; change=0 -> hold.
REQ-017 count_flat SHALL reflect an event on the edge that samples it (latency 1 cycle).
REQ-018 SAT=0: up from 2^WIDTH-1 SHALL give 0; down from 0 SHALL give 2^WIDTH-1; ovf_evt[i] pulses that cycle.
REQ-019 SAT=1: up at 2^WIDTH-1 and down at 0 SHALL hold value; ovf_evt[i] pulses each such blocked attempt.
REQ-020 ovf_evt SHALL be registered, aligned with the count update, and 0 in every other cycle.
REQ-021 alarm[i] SHALL be registered from the next-count value so alarm and count change on the same edge.
REQ-022 total SHALL equal the sum of count_flat values from the previous cycle (latency 2 cycles from event), never wrapping.
REQ-023 clr SHALL take priority over change on every channel; clr forces ovf_evt to 0.
REQ-024 Channels SHALL be fully independent; simultaneous events on all channels SHALL all apply in one cycle.

Reset
REQ-025 rst low SHALL immediately set every counter to INIT, total to NCH*INIT, ovf_evt to 0, peaks to INIT, alarm to (INIT >= ALARM_TH).
REQ-026 Reset release SHALL take effect at the first rising clk edge after rst returns high; assertion mid-count aborts pending updates.

Configuration
REQ-027 Macro MON_PEAK_EN defined: peak_flat[i] SHALL track max count[i] since reset/clr, updated same edge as count.
REQ-028 MON_PEAK_EN undefined: peak logic SHALL be absent and peak_flat SHALL be constant 0.

Structure
REQ-029 Shared package monitor_pkg SHALL hold the mode constants (MODE_WRAP=0, MODE_SAT=1) and the total-width function.
REQ-030 Per-channel counter, ovf, alarm and peak logic SHALL live in sub-module monitor_channel, instantiated NCH times by generate; summing tree stays in top.

Verification
REQ-031 Reset: rst low with INIT=3, NCH=4 -> counts 3, total 12, ovf_evt 0, peaks 3.
REQ-032 Wrap: SAT=0, WIDTH=8, ch0 at 255, change=1 on_off=1 -> ch0=0, ovf_evt[0] one cycle; from 0 down -> 255 with pulse.
REQ-033 Saturate: SAT=1, ch1 at 0, three down events -> ch1 stays 0, ovf_evt[1] high three cycles; at 255 up -> holds 255.
REQ-034 Concurrency/total: all 4 channels up 10 cycles from 0 -> each 10 after cycle 10, total 40 one cycle later; clr with change -> all INIT.
REQ-035 Alarm/peak: ALARM_TH=5, ch2 up to 6 then down to 2 -> alarm[2] high at 5,6, low at 4; peak 6 with MON_PEAK_EN, 0 without.

Source files
------------

// File: rtl/monitor_pkg.sv
// rtl/monitor_pkg.sv - shared mode constants and width helper for the pool monitor
package monitor_pkg;

  // Arithmetic mode selectors for the per-channel counters
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Width of the running total: worst case NCH * (2^WIDTH - 1) never wraps
  function automatic int total_width(input int width, input int nch);
    return width + $clog2(nch) + 1;
  endfunction

endpackage

// File: rtl/monitor_channel.sv
// rtl/monitor_channel.sv - one device channel: up/down counter, overflow pulse, alarm, peak (MON_PEAK_EN)
module monitor_channel
  import monitor_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int INIT     = 0,
  parameter int SAT      = MODE_WRAP,
  parameter int ALARM_TH = (1 << WIDTH) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             change,
  input  logic             on_off,
  output logic [WIDTH-1:0] count,
  output logic             alarm,
  output logic             ovf_evt,
  output logic [WIDTH-1:0] peak
);

  localparam logic [WIDTH-1:0] CMAX      = '1;
  localparam logic [WIDTH-1:0] INIT_V    = WIDTH'(INIT);
  localparam logic [31:0]      TH        = 32'(ALARM_TH);
  localparam logic             ALARM_RST = (32'(INIT) >= TH);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             alarm_q, alarm_d;

  // Next count: clear wins, then up/down with wrap or saturate at the ends
  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    if (clr) begin
      count_d = INIT_V;
    end else if (change) begin
      if (on_off) begin
        if (count_q == CMAX) begin
          ovf_d   = 1'b1;
          count_d = (SAT == MODE_SAT) ? CMAX : '0;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          ovf_d   = 1'b1;
          count_d = (SAT == MODE_SAT) ? '0 : CMAX;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
    // alarm is derived from the next count so it moves on the same edge as count
    alarm_d = (32'(count_d) >= TH);
  end

  // Counter, overflow pulse and alarm registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= INIT_V;
      ovf_q   <= 1'b0;
      alarm_q <= ALARM_RST;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      alarm_q <= alarm_d;
    end
  end

  assign count   = count_q;
  assign ovf_evt = ovf_q;
  assign alarm   = alarm_q;

`ifdef MON_PEAK_EN
  logic [WIDTH-1:0] peak_q, peak_d;

  // High-water mark since reset or clear, compared against the next count
  always_comb begin
    peak_d = peak_q;
    if (clr) begin
      peak_d = INIT_V;
    end else if (count_d > peak_q) begin
      peak_d = count_d;
    end
  end

  // Peak register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      peak_q <= INIT_V;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak = peak_q;
`else
  assign peak = '0;
`endif

endmodule

// File: rtl/iot_pool_monitor.sv
// rtl/iot_pool_monitor.sv - NCH device channels plus registered total; peak tracking under MON_PEAK_EN
module iot_pool_monitor
  import monitor_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int WIDTH    = 8,
  parameter int INIT     = 0,
  parameter int SAT      = MODE_WRAP,
  parameter int ALARM_TH = (1 << WIDTH) - 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clr,
  input  logic [NCH-1:0]                       change,
  input  logic [NCH-1:0]                       on_off,
  output logic [NCH*WIDTH-1:0]                 count_flat,
  output logic [total_width(WIDTH, NCH)-1:0]   total,
  output logic [NCH-1:0]                       alarm,
  output logic [NCH-1:0]                       ovf_evt,
  output logic [NCH*WIDTH-1:0]                 peak_flat
);

  localparam int TW = total_width(WIDTH, NCH);

  logic [NCH-1:0][WIDTH-1:0] count_w;
  logic [NCH-1:0][WIDTH-1:0] peak_w;
  logic [TW-1:0]             total_q, total_d;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    monitor_channel #(
      .WIDTH    (WIDTH),
      .INIT     (INIT),
      .SAT      (SAT),
      .ALARM_TH (ALARM_TH)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .change  (change[i]),
      .on_off  (on_off[i]),
      .count   (count_w[i]),
      .alarm   (alarm[i]),
      .ovf_evt (ovf_evt[i]),
      .peak    (peak_w[i])
    );
  end

  assign count_flat = count_w;
  assign peak_flat  = peak_w;

  // Sum of the registered channel counts; widened so it cannot wrap
  always_comb begin
    total_d = '0;
    for (int i = 0; i < NCH; i++) begin
      total_d = total_d + TW'(count_w[i]);
    end
  end

  // Total register: one cycle behind the counts
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      total_q <= TW'(NCH * INIT);
    end else begin
      total_q <= total_d;
    end
  end

  assign total = total_q;

endmodule

// File: tb/tb_iot_pool_monitor.sv
// tb/tb_iot_pool_monitor.sv - directed vector bench for iot_pool_monitor (wrap/alarm DUT and saturate/INIT DUT)
module tb_iot_pool_monitor;

`ifdef MON_PEAK_EN
  localparam bit PEAK_ON = 1'b1;
`else
  localparam bit PEAK_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic a_clr, b_clr;
  logic [3:0] a_change, a_on, b_change, b_on;
  logic [31:0] a_cnt, b_cnt, a_peak, b_peak;
  logic [10:0] a_total, b_total;
  logic [3:0] a_alarm, b_alarm, a_ovf, b_ovf;

  int n_total = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  iot_pool_monitor #(.NCH(4), .WIDTH(8), .INIT(0), .SAT(0), .ALARM_TH(5)) dut_a (
    .clk(clk), .rst(rst), .clr(a_clr), .change(a_change), .on_off(a_on),
    .count_flat(a_cnt), .total(a_total), .alarm(a_alarm), .ovf_evt(a_ovf), .peak_flat(a_peak)
  );

  iot_pool_monitor #(.NCH(4), .WIDTH(8), .INIT(3), .SAT(1)) dut_b (
    .clk(clk), .rst(rst), .clr(b_clr), .change(b_change), .on_off(b_on),
    .count_flat(b_cnt), .total(b_total), .alarm(b_alarm), .ovf_evt(b_ovf), .peak_flat(b_peak)
  );

  typedef struct {
    logic        clr;
    logic [3:0]  change;
    logic [3:0]  on_off;
    logic [31:0] cnt;
    logic [3:0]  alarm;
    logic [3:0]  ovf;
    logic [31:0] peak;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step_a(input logic c, input logic [3:0] ch, input logic [3:0] on);
    a_clr = c; a_change = ch; a_on = on;
    @(posedge clk); #1;
  endtask

  task automatic step_b(input logic c, input logic [3:0] ch, input logic [3:0] on);
    b_clr = c; b_change = ch; b_on = on;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev_sum;
    int s;
    logic [31:0] pk_exp;

    rst = 1'b1;
    a_clr = 0; a_change = 0; a_on = 0;
    b_clr = 0; b_change = 0; b_on = 0;

    //                clr   change    on_off    count          alarm    ovf      peak
    vecs[0]  = '{1'b0, 4'b0001, 4'b0000, 32'h000000FF, 4'b0001, 4'b0001, 32'h000000FF};
    vecs[1]  = '{1'b0, 4'b0001, 4'b0001, 32'h00000000, 4'b0000, 4'b0001, 32'h000000FF};
    vecs[2]  = '{1'b0, 4'b0000, 4'b0000, 32'h00000000, 4'b0000, 4'b0000, 32'h000000FF};
    vecs[3]  = '{1'b0, 4'b1111, 4'b1111, 32'h01010101, 4'b0000, 4'b0000, 32'h010101FF};
    vecs[4]  = '{1'b0, 4'b1111, 4'b1111, 32'h02020202, 4'b0000, 4'b0000, 32'h020202FF};
    vecs[5]  = '{1'b0, 4'b0100, 4'b0100, 32'h02030202, 4'b0000, 4'b0000, 32'h020302FF};
    vecs[6]  = '{1'b0, 4'b0100, 4'b0100, 32'h02040202, 4'b0000, 4'b0000, 32'h020402FF};
    vecs[7]  = '{1'b0, 4'b0100, 4'b0100, 32'h02050202, 4'b0100, 4'b0000, 32'h020502FF};
    vecs[8]  = '{1'b0, 4'b0100, 4'b0100, 32'h02060202, 4'b0100, 4'b0000, 32'h020602FF};
    vecs[9]  = '{1'b0, 4'b0100, 4'b0000, 32'h02050202, 4'b0100, 4'b0000, 32'h020602FF};
    vecs[10] = '{1'b0, 4'b0100, 4'b0000, 32'h02040202, 4'b0000, 4'b0000, 32'h020602FF};
    vecs[11] = '{1'b0, 4'b0100, 4'b0000, 32'h02030202, 4'b0000, 4'b0000, 32'h020602FF};
    vecs[12] = '{1'b0, 4'b0100, 4'b0000, 32'h02020202, 4'b0000, 4'b0000, 32'h020602FF};
    vecs[13] = '{1'b0, 4'b1010, 4'b1000, 32'h03020102, 4'b0000, 4'b0000, 32'h030602FF};
    vecs[14] = '{1'b1, 4'b1111, 4'b1111, 32'h00000000, 4'b0000, 4'b0000, 32'h00000000};
    vecs[15] = '{1'b1, 4'b0001, 4'b0000, 32'h00000000, 4'b0000, 4'b0000, 32'h00000000};

    // asynchronous reset, checked before any clock edge
    #1 rst = 1'b0;
    #1;
    chk("rst a cnt", a_cnt, 32'h0);
    chk("rst a total", a_total, 11'd0);
    chk("rst a ovf", a_ovf, 4'h0);
    chk("rst a alarm", a_alarm, 4'h0);
    chk("rst b cnt", b_cnt, 32'h03030303);
    chk("rst b total", b_total, 11'd12);
    chk("rst b ovf", b_ovf, 4'h0);
    chk("rst b alarm", b_alarm, 4'h0);
    chk("rst b peak", b_peak, PEAK_ON ? 32'h03030303 : 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    // table: wrap both directions, alarm threshold, clear priority, total latency
    prev_sum = 0;
    for (int i = 0; i < 16; i++) begin
      step_a(vecs[i].clr, vecs[i].change, vecs[i].on_off);
      pk_exp = PEAK_ON ? vecs[i].peak : 32'h0;
      chk($sformatf("row%0d cnt", i), a_cnt, vecs[i].cnt);
      chk($sformatf("row%0d alarm", i), a_alarm, vecs[i].alarm);
      chk($sformatf("row%0d ovf", i), a_ovf, vecs[i].ovf);
      chk($sformatf("row%0d peak", i), a_peak, pk_exp);
      chk($sformatf("row%0d total", i), a_total, 11'(prev_sum));
      s = 0;
      for (int k = 0; k < 4; k++) s += int'(vecs[i].cnt[k*8 +: 8]);
      prev_sum = s;
    end

    // all channels up together for ten cycles
    for (int c = 0; c < 10; c++) step_a(1'b0, 4'hF, 4'hF);
    chk("conc cnt", a_cnt, 32'h0A0A0A0A);
    chk("conc total lag", a_total, 11'd36);
    chk("conc alarm", a_alarm, 4'hF);
    step_a(1'b0, 4'h0, 4'h0);
    chk("conc total", a_total, 11'd40);
    chk("conc hold", a_cnt, 32'h0A0A0A0A);

    // saturating DUT: ch1 down from 3 to 0, then three blocked attempts
    for (int c = 0; c < 3; c++) begin
      step_b(1'b0, 4'b0010, 4'b0000);
      chk($sformatf("sat dn%0d ovf", c), b_ovf, 4'h0);
    end
    chk("sat at0 cnt", b_cnt, 32'h03030003);
    for (int c = 0; c < 3; c++) begin
      step_b(1'b0, 4'b0010, 4'b0000);
      chk($sformatf("sat blk%0d cnt", c), b_cnt, 32'h03030003);
      chk($sformatf("sat blk%0d ovf", c), b_ovf, 4'b0010);
    end
    step_b(1'b0, 4'h0, 4'h0);
    chk("sat idle ovf", b_ovf, 4'h0);

    // ch1 up to the top, then one blocked up
    for (int c = 0; c < 255; c++) step_b(1'b0, 4'b0010, 4'b0010);
    chk("sat top cnt", b_cnt, 32'h0303FF03);
    chk("sat top ovf", b_ovf, 4'h0);
    chk("sat top alarm", b_alarm, 4'b0010);
    step_b(1'b0, 4'b0010, 4'b0010);
    chk("sat hold cnt", b_cnt, 32'h0303FF03);
    chk("sat hold ovf", b_ovf, 4'b0010);
    step_b(1'b0, 4'h0, 4'h0);
    chk("sat post ovf", b_ovf, 4'h0);
    chk("sat total", b_total, 11'd264);
    chk("sat peak", b_peak, PEAK_ON ? 32'h0303FF03 : 32'h0);

    // clear beats simultaneous change
    step_b(1'b1, 4'hF, 4'hF);
    chk("clr cnt", b_cnt, 32'h03030303);
    chk("clr ovf", b_ovf, 4'h0);
    chk("clr alarm", b_alarm, 4'h0);
    chk("clr peak", b_peak, PEAK_ON ? 32'h03030303 : 32'h0);
    step_b(1'b0, 4'hF, 4'hF);
    chk("post clr cnt", b_cnt, 32'h04040404);

    // reset asserted mid-count, with events still requested
    #2 rst = 1'b0;
    #1;
    chk("mid rst cnt", b_cnt, 32'h03030303);
    chk("mid rst total", b_total, 11'd12);
    chk("mid rst ovf", b_ovf, 4'h0);
    @(posedge clk); #1;
    chk("mid rst held", b_cnt, 32'h03030303);
    @(negedge clk);
    rst = 1'b1;
    b_change = 4'h0; b_on = 4'h0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
